ifmap_sp_writer: RTL and testbench
==================================

IFMAP_SP_WRITER -- requirements
Module: ifmap_sp_writer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, the scratchpad word width.
REQ-002 SHALL have parameter NUM_REG, default 12, the scratchpad depth; it need not be a power of two.
REQ-003 SHALL have parameter ADDR_WIDTH, default 4, the scratchpad address width, with 2^ADDR_WIDTH >= NUM_REG.
REQ-004 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: begin a fill stripe.
REQ-007 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, DATA_WIDTH): upstream stream handshake.
REQ-008 SHALL have port in_last, input, 1 bit: marks the final word of the stripe.
REQ-009 SHALL have ports rel_valid (input, 1) and rel_count (input, ADDR_WIDTH+1): the reader frees its rel_count oldest entries.
REQ-010 SHALL have ports wen (output, 1), waddr (output, ADDR_WIDTH) and din (output, DATA_WIDTH): scratchpad write port.
REQ-011 SHALL have port base_addr, output, ADDR_WIDTH: address of the oldest valid entry.
REQ-012 SHALL have port count, output, ADDR_WIDTH+1: number of valid entries.
REQ-013 SHALL have ports full (output, 1), done (output, 1) and rel_err (output, 1, sticky).

Function
REQ-014 SHALL implement FSM states IDLE, FILL and DONE.
REQ-015 Transitions SHALL be: IDLE->FILL on start; FILL->DONE on an accepted word with in_last=1; DONE->FILL on start; start in FILL SHALL be ignored.
REQ-016 in_ready SHALL equal (state==FILL) && (count<NUM_REG), combinationally.
REQ-017 An accept SHALL occur when in_valid && in_ready.
REQ-018 wen SHALL equal accept, with waddr=wptr and din=in_data in the same cycle (zero latency).
REQ-019 wptr SHALL advance by 1 per accept, wrapping NUM_REG-1 -> 0.
REQ-020 On rel_valid, base_addr SHALL advance by the applied release, modulo NUM_REG.
REQ-021 Applied release SHALL be min(rel_count, count), using count before the current cycle's accept.
REQ-022 rel_err SHALL set when rel_count > count and SHALL stay set until reset.
REQ-023 count_next SHALL equal count + accept - applied_release; a simultaneous accept and release SHALL both take effect.
REQ-024 full SHALL equal (count==NUM_REG); when full, in_ready=0 and upstream data SHALL be held, not dropped.
REQ-025 done SHALL be 1 exactly while state==DONE.
REQ-026 Releases SHALL be honoured in every state.
REQ-027 wptr and base_addr SHALL persist across stripes; only reset clears them.

Reset
REQ-028 rst SHALL asynchronously force: state=IDLE, wptr=0, base_addr=0, count=0, rel_err=0.
REQ-029 While in reset, outputs SHALL be: wen=0, in_ready=0, full=0, done=0.
REQ-030 Reset mid-FILL SHALL discard the stripe, with no further wen until the next start.

Structure
REQ-031 Package ifmap_sp_pkg SHALL hold the state encoding constants (IDLE=0, FILL=1, DONE=2).
REQ-032 A sub-module sp_ptr_wrap SHALL provide the mod-NUM_REG pointer add (ptr + inc, inc <= NUM_REG); it SHALL be instanced for both wptr and base_addr.
REQ-033 All state SHALL be held in flops clocked by clk with async rst; all outputs SHALL be flop outputs or simple gating of flops and inputs.

Verification (NUM_REG=4, DATA_WIDTH=16)
REQ-034 Basic fill: start, then 3 words 0xA1..0xA3 with in_last on the third -> wen on 3 cycles, waddr 0,1,2, count=3, done=1.
REQ-035 Full backpressure: 5 words offered with no release -> 4 accepts, then full=1 and in_ready=0; 0x...5 held until rel_valid with rel_count=1, then accepted at waddr 0 with base_addr=1.
REQ-036 Simultaneous events: count=4, accept impossible; count=3 with an accept and a release of 2 in the same cycle -> count=2.
REQ-037 Over-release: count=1 and rel_count=3 -> count=0, base_addr+1 mod 4, rel_err=1 until reset.
REQ-038 Reset mid-FILL: rst asserted after 2 accepts -> wen=0 immediately, count=0, base_addr=0; words offered after rst deasserts and before start -> in_ready=0.
REQ-039 Wrap: 3 stripes of 3 words with full releases -> waddr sequence 0,1,2,3,0,1,2,3,0; start while in FILL has no effect.

Source files
------------

// File: rtl/ifmap_sp_writer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : ifmap_sp_pkg                                               |
// | Brief   : Shared state encoding for the ifmap scratchpad writer.     |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package ifmap_sp_pkg;

  localparam int STATE_W = 2;

  // Writer control states.
  // The encoded values are fixed so that they can be observed from outside the block.
  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : ifmap_sp_pkg
`default_nettype wire

// File: rtl/ifmap_sp_writer_ptr_wrap.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sp_ptr_wrap                                                |
// | Brief   : Circular pointer add, (ptr + inc) mod NUM_REG, inc<=NUM_REG |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module sp_ptr_wrap #(
  parameter int NUM_REG    = 12,
  parameter int ADDR_WIDTH = 4
) (
  input  logic [ADDR_WIDTH-1:0] ptr,
  input  logic [ADDR_WIDTH:0]   inc,
  output logic [ADDR_WIDTH-1:0] sum
);

  localparam logic [ADDR_WIDTH:0] C_NUM_REG = (ADDR_WIDTH+1)'(NUM_REG);

  // ptr < NUM_REG and inc <= NUM_REG, so the raw sum is below 2*NUM_REG.
  // This means a single conditional subtract gives the modulo.
  // One extra bit holds the raw sum without overflow.
  logic [ADDR_WIDTH:0] w_raw;

  assign w_raw = {1'b0, ptr} + inc;

  // Fold back into the [0, NUM_REG) range.
  always_comb begin
    sum = ADDR_WIDTH'(w_raw);
    if (w_raw >= C_NUM_REG) begin
      sum = ADDR_WIDTH'(w_raw - C_NUM_REG);
    end
  end

endmodule : sp_ptr_wrap
`default_nettype wire

// File: rtl/ifmap_sp_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ifmap_sp_writer                                            |
// | Brief   : Fills a circular input-feature-map scratchpad from a       |
// |           valid/ready stream and tracks reader releases.             |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module ifmap_sp_writer
  import ifmap_sp_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REG    = 12,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  input  logic                  rel_valid,
  input  logic [ADDR_WIDTH:0]   rel_count,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] din,
  output logic [ADDR_WIDTH-1:0] base_addr,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  done,
  output logic                  rel_err
);

  localparam logic [ADDR_WIDTH:0] C_NUM_REG = (ADDR_WIDTH+1)'(NUM_REG);

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_rel_err;

  logic                  w_accept;
  logic [ADDR_WIDTH:0]   w_release;
  logic                  w_over;
  logic [ADDR_WIDTH:0]   w_count_next;
  logic [ADDR_WIDTH-1:0] w_wptr_next;
  logic [ADDR_WIDTH-1:0] w_base_next;

  // The upstream word is accepted only while a stripe is open and a slot is free.
  // A refused word stays on the bus and is not lost.
  assign in_ready  = (r_state == FILL) && (r_count < C_NUM_REG);
  assign w_accept  = in_valid && in_ready;

  assign wen       = w_accept;
  assign waddr     = r_wptr;
  assign din       = in_data;
  assign base_addr = r_base;
  assign count     = r_count;
  assign full      = (r_count == C_NUM_REG);
  assign done      = (r_state == DONE);
  assign rel_err   = r_rel_err;

  // Clamp the release to the entries that actually exist.
  // The clamp uses the occupancy before this cycle's write.
  always_comb begin
    w_release = '0;
    w_over    = 1'b0;
    if (rel_valid) begin
      if (rel_count > r_count) begin
        w_release = r_count;
        w_over    = 1'b1;
      end else begin
        w_release = rel_count;
      end
    end
  end

  assign w_count_next = r_count + {{ADDR_WIDTH{1'b0}}, w_accept} - w_release;

  sp_ptr_wrap #(
    .NUM_REG    (NUM_REG),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wptr_wrap (
    .ptr (r_wptr),
    .inc ({{ADDR_WIDTH{1'b0}}, w_accept}),
    .sum (w_wptr_next)
  );

  sp_ptr_wrap #(
    .NUM_REG    (NUM_REG),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_base_wrap (
    .ptr (r_base),
    .inc (w_release),
    .sum (w_base_next)
  );

  // Stripe control.
  // A start pulse is only honoured between stripes.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = FILL;
      FILL:    if (w_accept && in_last) w_state_next = DONE;
      DONE:    if (start) w_state_next = FILL;
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Ring pointers and occupancy.
  // These carry over between stripes; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr    <= '0;
      r_base    <= '0;
      r_count   <= '0;
      r_rel_err <= 1'b0;
    end else begin
      r_wptr  <= w_wptr_next;
      r_base  <= w_base_next;
      r_count <= w_count_next;
      if (w_over) begin
        r_rel_err <= 1'b1;
      end
    end
  end

endmodule : ifmap_sp_writer
`default_nettype wire

// File: tb/tb_ifmap_sp_writer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_ifmap_sp_writer                                         |
// | Brief   : Self-checking bench for ifmap_sp_writer (NUM_REG=4).       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_ifmap_sp_writer;

  localparam int DW = 16;
  localparam int NR = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          rel_valid = 1'b0;
  logic [AW:0]   rel_count = '0;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [DW-1:0] din;
  logic [AW-1:0] base_addr;
  logic [AW:0]   count;
  logic          full;
  logic          done;
  logic          rel_err;

  int n_checks = 0;
  int n_fail   = 0;

  ifmap_sp_writer #(
    .DATA_WIDTH (DW),
    .NUM_REG    (NR),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .rel_valid (rel_valid),
    .rel_count (rel_count),
    .wen       (wen),
    .waddr     (waddr),
    .din       (din),
    .base_addr (base_addr),
    .count     (count),
    .full      (full),
    .done      (done),
    .rel_err   (rel_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Reference model.
  // The occupancy is total words accepted minus total entries released.
  // Both pointers are those running totals taken modulo NR.
  int m_acc   = 0;
  int m_rel   = 0;
  int m_phase = 0;   // 0 idle, 1 filling, 2 stripe finished
  int m_err   = 0;

  always @(posedge clk or posedge rst) begin
    int cnt, acc, rl;
    if (rst) begin
      m_acc = 0; m_rel = 0; m_phase = 0; m_err = 0;
    end else begin
      cnt = m_acc - m_rel;
      acc = (m_phase == 1 && cnt < NR && in_valid) ? 1 : 0;
      rl  = 0;
      if (rel_valid) begin
        rl = (int'(rel_count) > cnt) ? cnt : int'(rel_count);
        if (int'(rel_count) > cnt) m_err = 1;
      end
      if (m_phase == 1 && acc == 1 && in_last) m_phase = 2;
      else if (m_phase != 1 && start) m_phase = 1;
      m_acc += acc;
      m_rel += rl;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    int cnt, rdy, we;
    cnt = m_acc - m_rel;
    rdy = (m_phase == 1 && cnt < NR) ? 1 : 0;
    we  = (rdy == 1 && in_valid) ? 1 : 0;
    chk("m_in_ready", int'(in_ready), rdy);
    chk("m_wen", int'(wen), we);
    if (we == 1) begin
      chk("m_waddr", int'(waddr), m_acc % NR);
      chk("m_din", int'(din), int'(in_data));
    end
    chk("m_base_addr", int'(base_addr), m_rel % NR);
    chk("m_count", int'(count), cnt);
    chk("m_full", int'(full), (cnt == NR) ? 1 : 0);
    chk("m_done", int'(done), (m_phase == 2) ? 1 : 0);
    chk("m_rel_err", int'(rel_err), m_err);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int w;
  int rec[$];
  logic [AW-1:0] exp_wrap[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};

  initial begin
    // Reset state, with a word offered so that a leaking wen would show.
    in_valid = 1'b1;
    tick();
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_wen", int'(wen), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_count", int'(count), 0);
    in_valid = 1'b0;
    rst = 1'b0;

    // Basic fill.
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 16'h00A1; #1;
    chk("fill_wen0", int'(wen), 1); chk("fill_waddr0", int'(waddr), 0);
    tick(); in_data = 16'h00A2; #1;
    chk("fill_waddr1", int'(waddr), 1);
    tick(); in_data = 16'h00A3; in_last = 1'b1; #1;
    chk("fill_waddr2", int'(waddr), 2); chk("fill_din2", int'(din), 16'h00A3);
    tick(); in_valid = 1'b0; in_last = 1'b0; #1;
    chk("fill_count", int'(count), 3); chk("fill_done", int'(done), 1);

    // Full backpressure.
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; w = 1;
    for (int k = 0; k < 8; k++) begin
      in_data = 16'hB000 + 16'(w); #1;
      if (in_ready) w++;
      tick();
    end
    in_data = 16'hB005;
    chk("bp_accepts", w - 1, 4);
    chk("bp_full", int'(full), 1);
    chk("bp_in_ready", int'(in_ready), 0);
    rel_valid = 1'b1; rel_count = 3'd1; #1;
    chk("bp_hold_wen", int'(wen), 0);
    tick(); rel_valid = 1'b0; #1;
    chk("bp_count_after_rel", int'(count), 3);
    chk("bp_base", int'(base_addr), 1);
    chk("bp_wen5", int'(wen), 1);
    chk("bp_waddr5", int'(waddr), 0);
    chk("bp_din5", int'(din), 16'hB005);
    tick(); in_valid = 1'b0; #1;
    chk("bp_count_refull", int'(count), 4);

    // Simultaneous events: full blocks the accept, then accept plus release 2.
    in_valid = 1'b1; in_data = 16'hC001; rel_valid = 1'b1; rel_count = 3'd1; #1;
    chk("sim_full_wen", int'(wen), 0);
    tick(); rel_count = 3'd2; #1;
    chk("sim_wen", int'(wen), 1);
    tick(); in_valid = 1'b0; rel_valid = 1'b0; #1;
    chk("sim_count", int'(count), 2);
    chk("sim_base", int'(base_addr), 0);

    // Over-release.
    rel_valid = 1'b1; rel_count = 3'd1; tick();
    chk("ovr_pre_count", int'(count), 1);
    rel_count = 3'd3; tick(); rel_valid = 1'b0; #1;
    chk("ovr_count", int'(count), 0);
    chk("ovr_base", int'(base_addr), 2);
    chk("ovr_err", int'(rel_err), 1);
    tick(); tick();
    chk("ovr_err_sticky", int'(rel_err), 1);

    // Reset mid-fill.
    do_reset(); #1;
    chk("rmf_err_cleared", int'(rel_err), 0);
    start = 1'b1; tick(); start = 1'b0;
    in_valid = 1'b1; in_data = 16'hD001; tick();
    in_data = 16'hD002; tick();
    in_data = 16'hD003; #1;
    chk("rmf_pre_wen", int'(wen), 1);
    rst = 1'b1; #1;
    chk("rmf_wen", int'(wen), 0);
    chk("rmf_count", int'(count), 0);
    chk("rmf_base", int'(base_addr), 0);
    tick(); rst = 1'b0; #1;
    chk("rmf_ready0", int'(in_ready), 0);
    tick();
    chk("rmf_ready1", int'(in_ready), 0);
    chk("rmf_wen1", int'(wen), 0);
    in_valid = 1'b0;

    // Wrap over three stripes; start pulses inside a stripe are ignored.
    do_reset();
    for (int s = 0; s < 3; s++) begin
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        in_valid = 1'b1; in_data = 16'(16'hE000 + s * 16 + i);
        in_last = (i == 2); start = (i == 1); #1;
        if (wen) rec.push_back(int'(waddr));
        tick();
      end
      in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
      chk("wrap_done", int'(done), 1);
      rel_valid = 1'b1; rel_count = 3'd3; tick(); rel_valid = 1'b0;
    end
    chk("wrap_n", rec.size(), 9);
    for (int i = 0; i < 9 && i < rec.size(); i++) chk("wrap_waddr", rec[i], int'(exp_wrap[i]));

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      start     = ($urandom % 8) == 0;
      in_valid  = ($urandom % 4) != 0;
      in_data   = 16'($urandom);
      in_last   = ($urandom % 6) == 0;
      rel_valid = ($urandom % 3) == 0;
      rel_count = 3'($urandom_range(0, 5));
      rst       = ($urandom % 300) == 0;
      tick();
    end
    rst = 1'b0; in_valid = 1'b0; rel_valid = 1'b0; start = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ifmap_sp_writer
`default_nettype wire
